regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two writeback sources: ALU results and memory load results.
- Keeps a per-register pending scoreboard. Issue logic uses it to detect RAW hazards and to stall WAW re-issue.
- Sits between the execute/memory stages and the register file.
- Drives the file's wen/wsel/wdata inputs from registered outputs, so the negedge write lands in the cycle after a grant.

---
 rtl/regfile_wb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single write port of the register file between the
//            ALU writeback path and the memory-load writeback path, and keeps
//            a per-register pending scoreboard for RAW/WAW hazard detection.
//            The register-file write controls are registered, so a grant at
//            posedge k drives the file during cycle k..k+1 and the file
//            commits the data at the negedge inside that cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1       clock, all state updates on posedge
//   rst          in   1       synchronous reset, active low
//   alu_valid    in   1       ALU writeback request
//   alu_ready    out  1       ALU request accepted this cycle
//   alu_rd       in   ADDR_W  ALU destination register
//   alu_data     in   DATA_W  ALU result
//   mem_valid    in   1       load writeback request
//   mem_ready    out  1       load request accepted this cycle
//   mem_rd       in   ADDR_W  load destination register
//   mem_data     in   DATA_W  load result
//   issue_valid  in   1       instruction writing issue_rd wants to issue
//   issue_ready  out  1       issue allowed (no WAW on issue_rd)
//   issue_rd     in   ADDR_W  destination of the issuing instruction
//   issue_rs1    in   ADDR_W  source 1 to check
//   issue_rs2    in   ADDR_W  source 2 to check
//   hazard_rs1   out  1       issue_rs1 has an outstanding write
//   hazard_rs2   out  1       issue_rs2 has an outstanding write
//   rf_wen       out  1       register file write enable (registered)
//   rf_wsel      out  ADDR_W  register file write index (registered)
//   rf_wdata     out  DATA_W  register file write data (registered)
//   busy_mask    out  NREG    pending bits (registered)
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  output logic              hazard_rs1,
  output logic              hazard_rs2,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_wsel,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   busy_mask
);

  // Single-bit one-hot seed used to build per-index set/clear vectors.
  localparam logic [NREG-1:0] ONE_HOT_LSB = {{(NREG-1){1'b0}}, 1'b1};

  // Which source won the most recent tie. Resetting to MEM makes the ALU
  // win the first tie after reset.
  typedef enum logic [0:0] {
    LG_ALU = 1'b0,
    LG_MEM = 1'b1
  } last_grant_t;

  last_grant_t       last_grant;
  logic [NREG-1:0]   pending;

  logic              grant_alu;
  logic              grant_mem;
  logic              accept;
  logic [ADDR_W-1:0] accept_rd;
  logic [DATA_W-1:0] accept_data;
  logic              issue_fire;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic [NREG-1:0]   pending_next;

  // --------------------------------------------------------------------------
  // Arbitration: a lone request is always granted; on a tie the source that
  // did not win the previous tie is granted. last_grant only moves on ties,
  // so an uncontended stream does not disturb the tie order.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_valid && mem_valid) begin
      grant_alu = (last_grant == LG_MEM);
      grant_mem = (last_grant == LG_ALU);
    end else begin
      grant_alu = alu_valid;
      grant_mem = mem_valid;
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Mux the accepted request onto the single write path.
  always_comb begin
    accept      = grant_alu | grant_mem;
    accept_rd   = '0;
    accept_data = '0;
    if (grant_alu) begin
      accept_rd   = alu_rd;
      accept_data = alu_data;
    end else if (grant_mem) begin
      accept_rd   = mem_rd;
      accept_data = mem_data;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard. The clear is driven by the registered write port, so a bit
  // drops on the edge that ends the cycle in which the file was written.
  // Applying the set after the clear makes a same-edge set win.
  // --------------------------------------------------------------------------
  assign issue_ready = (issue_rd == '0) || !pending[issue_rd];
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_fire && (issue_rd != '0)) begin
      set_vec = ONE_HOT_LSB << issue_rd;
    end
    if (rf_wen) begin
      clr_vec = ONE_HOT_LSB << rf_wsel;
    end
    // x0 is hard-wired: its pending bit can never be set.
    pending_next = ((pending & ~clr_vec) | set_vec) & ~ONE_HOT_LSB;
  end

  // Hazards come straight from registered state; x0 reads 0 because its
  // pending bit is forced low.
  assign hazard_rs1 = pending[issue_rs1];
  assign hazard_rs2 = pending[issue_rs2];
  assign busy_mask  = pending;

  // --------------------------------------------------------------------------
  // Registered state: write port, tie pointer, scoreboard.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wen     <= 1'b0;
      rf_wsel    <= '0;
      rf_wdata   <= '0;
      last_grant <= LG_MEM;
      pending    <= '0;
    end else begin
      // A write to x0 is consumed but never reaches the file; the index and
      // data registers keep their previous contents in that case.
      rf_wen <= accept && (accept_rd != '0);
      if (accept && (accept_rd != '0)) begin
        rf_wsel  <= accept_rd;
        rf_wdata <= accept_data;
      end

      if (alu_valid && mem_valid) begin
        last_grant <= grant_alu ? LG_ALU : LG_MEM;
      end

      pending <= pending_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter: directed scenarios
//            followed by constrained-random traffic, all compared against a
//            behavioural model of arbitration, write port and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          issue_valid, issue_ready;
  logic [AW-1:0] issue_rd, issue_rs1, issue_rs2;
  logic          hazard_rs1, hazard_rs2;
  logic          rf_wen;
  logic [AW-1:0] rf_wsel;
  logic [DW-1:0] rf_wdata;
  logic [NREG-1:0] busy_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata), .busy_mask(busy_mask)
  );

  // Reference model state
  bit            m_pend [NREG];
  bit            m_alu_first;   // ALU wins the next tie
  logic          m_wen;
  logic [AW-1:0] m_wsel;
  logic [DW-1:0] m_wdata;
  bit            exp_ga, exp_gm, exp_ir;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] pend_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_write(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    m_wen = (rd != 0);
    if (rd != 0) begin
      m_wsel  = rd;
      m_wdata = d;
    end
  endtask

  // One clock cycle: predict and check combinational outputs for the current
  // inputs, advance the model at the edge, then check registered outputs.
  // Called at posedge+1 with inputs already driven; returns at posedge+1.
  task automatic cycle();
    exp_ga = alu_valid && (!mem_valid || m_alu_first);
    exp_gm = mem_valid && !exp_ga;
    exp_ir = (issue_rd == 0) || !m_pend[issue_rd];
    #1;
    if (rst) begin
      check("alu_ready",   64'(alu_ready),   64'(exp_ga));
      check("mem_ready",   64'(mem_ready),   64'(exp_gm));
      check("issue_ready", 64'(issue_ready), 64'(exp_ir));
      check("hazard_rs1",  64'(hazard_rs1),  64'(m_pend[issue_rs1]));
      check("hazard_rs2",  64'(hazard_rs2),  64'(m_pend[issue_rs2]));
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      m_alu_first = 1'b1;
      m_wen   = 1'b0;
      m_wsel  = '0;
      m_wdata = '0;
      exp_ga  = 1'b0;
      exp_gm  = 1'b0;
    end else begin
      // A write clears its register one edge after it was granted; a
      // same-edge issue to that register re-marks it.
      if (m_wen) m_pend[m_wsel] = 1'b0;
      if (issue_valid && exp_ir && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (alu_valid && mem_valid) m_alu_first = exp_gm;
      if (exp_ga)      model_write(alu_rd, alu_data);
      else if (exp_gm) model_write(mem_rd, mem_data);
      else             m_wen = 1'b0;
    end
    #1;
    check("rf_wen",    64'(rf_wen),    64'(m_wen));
    check("rf_wsel",   64'(rf_wsel),   64'(m_wsel));
    check("rf_wdata",  64'(rf_wdata),  64'(m_wdata));
    check("busy_mask", 64'(busy_mask), 64'(pend_vec()));
  endtask

  initial begin : stim
    logic [AW-1:0]   seq [6];
    logic [AW-1:0]   exp_seq [6];
    logic [NREG-1:0] snap;
    int ai, mi;
    bit alu_hold, mem_hold;

    exp_seq = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};
    m_alu_first = 1'b1;
    m_wen = 1'b0; m_wsel = '0; m_wdata = '0;
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;

    // Reset held two cycles with a live ALU request
    cycle();
    cycle();
    check("rst_wen",  64'(rf_wen),    64'd0);
    check("rst_busy", 64'(busy_mask), 64'd0);

    // Single write: rd=5, 0xDEADBEEF
    rst = 1'b1;
    alu_data = 32'hDEAD_BEEF;
    #1 check("first_alu_ready", 64'(alu_ready), 64'd1);
    cycle();
    check("single_wen",   64'(rf_wen),   64'd1);
    check("single_wsel",  64'(rf_wsel),  64'd5);
    check("single_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    alu_valid = 1'b0;
    cycle();
    check("single_wen_off", 64'(rf_wen), 64'd0);

    // Contention: ALU rd 1,2,3 vs MEM rd 4,5,6
    ai = 0; mi = 0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = $urandom;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = $urandom;
    for (int c = 0; c < 6; c++) begin
      cycle();
      seq[c] = rf_wsel;
      check("cont_wen", 64'(rf_wen), 64'd1);
      if (exp_ga) begin ai++; alu_data = $urandom; end
      else if (exp_gm) begin mi++; mem_data = $urandom; end
      alu_valid = (ai < 3);
      alu_rd    = AW'(ai + 1);
      mem_valid = (mi < 3);
      mem_rd    = AW'(mi + 4);
    end
    for (int c = 0; c < 6; c++) check("cont_order", 64'(seq[c]), 64'(exp_seq[c]));
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();

    // RAW on register 7
    issue_valid = 1'b1; issue_rd = 5'd7; issue_rs1 = 5'd7; issue_rs2 = 5'd0;
    cycle();
    issue_valid = 1'b0;
    check("raw_haz_set", 64'(hazard_rs1), 64'd1);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = $urandom;
    cycle();
    mem_valid = 1'b0;
    check("raw_haz_during_write", 64'(hazard_rs1), 64'd1);
    check("raw_wsel", 64'(rf_wsel), 64'd7);
    cycle();
    check("raw_haz_clear", 64'(hazard_rs1), 64'd0);

    // WAW on register 9: re-issue stalls during the write cycle
    issue_valid = 1'b1; issue_rd = 5'd9;
    cycle();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = $urandom;
    cycle();
    mem_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1 check("waw_stall", 64'(issue_ready), 64'd0);
    cycle();
    #1 check("waw_release", 64'(issue_ready), 64'd1);
    cycle();
    issue_valid = 1'b0;
    check("waw_reissued", 64'(busy_mask[9]), 64'd1);

    // Set and clear of register 3 on the same edge
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = $urandom;
    cycle();
    mem_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    cycle();
    issue_valid = 1'b0;
    check("same_edge_set_wins", 64'(busy_mask[3]), 64'd1);

    // x0 handling
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    #1 check("x0_alu_ready", 64'(alu_ready), 64'd1);
    cycle();
    alu_valid = 1'b0;
    check("x0_no_wen", 64'(rf_wen), 64'd0);
    snap = pend_vec();
    issue_valid = 1'b1; issue_rd = 5'd0; issue_rs2 = 5'd0;
    cycle();
    issue_valid = 1'b0;
    check("x0_busy_unchanged", 64'(busy_mask), 64'(snap));
    check("x0_hazard_rs2", 64'(hazard_rs2), 64'd0);

    // Constrained-random traffic; held requests stay stable until accepted
    alu_hold = 1'b0; mem_hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      if (!alu_hold) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = AW'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!mem_hold) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = AW'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      issue_valid = $urandom_range(0, 1);
      issue_rd    = AW'($urandom_range(0, 7));
      issue_rs1   = AW'($urandom_range(0, 7));
      issue_rs2   = AW'($urandom_range(0, 7));
      cycle();
      alu_hold = alu_valid && !exp_ga;
      mem_hold = mem_valid && !exp_gm;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
